// File: rtl/pe_db_if.sv
// rtl/pe_db_if.sv - operand, psum and forwarding bundle for one pe_db grid point
//
// Purpose: groups the per-cycle op/data inputs and registered outputs of a PE.
// Ports (slave view = the PE):
//   in : operation_signal_in[3], valid_in, act_data_in, wgt_data_in, result_in
//   out: act_data_out, wgt_data_out, result_out, valid_out, sat_flag
interface pe_db_if #(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32
);
    logic [2:0]              operation_signal_in;
    logic                    valid_in;
    logic [ACT_WIDTH-1:0]    act_data_in;
    logic [WGT_WIDTH-1:0]    wgt_data_in;
    logic [PE_OUT_WIDTH-1:0] result_in;
    logic [ACT_WIDTH-1:0]    act_data_out;
    logic [WGT_WIDTH-1:0]    wgt_data_out;
    logic [PE_OUT_WIDTH-1:0] result_out;
    logic                    valid_out;
    logic                    sat_flag;

    modport slave (
        input  operation_signal_in, valid_in, act_data_in, wgt_data_in, result_in,
        output act_data_out, wgt_data_out, result_out, valid_out, sat_flag
    );

    modport master (
        output operation_signal_in, valid_in, act_data_in, wgt_data_in, result_in,
        input  act_data_out, wgt_data_out, result_out, valid_out, sat_flag
    );
endinterface

// File: rtl/pe_db.sv
// rtl/pe_db.sv - double-buffered WS/OS systolic processing element
//
// Purpose: one MAC cell supporting weight-stationary flow (psum passes through,
// weight held in w_active with a shadow copy loadable in the background) and
// output-stationary flow (local accumulator, flushed then drained downstream).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears every register
//   bus   - pe_db_if.slave: op code, valid, act/wgt/psum in; registered
//           act/wgt forwarding, result, valid and sticky sat_flag out
// Assumes MULT_OUT_WIDTH >= ACT_WIDTH, >= WGT_WIDTH and PE_OUT_WIDTH >= MULT_OUT_WIDTH.
module pe_db #(
    parameter int ACT_WIDTH      = 8,
    parameter int WGT_WIDTH      = 8,
    parameter int MULT_OUT_WIDTH = ACT_WIDTH + WGT_WIDTH,
    parameter int PE_OUT_WIDTH   = 32,
    parameter int SIGNED         = 0,
    parameter int SATURATE       = 0
) (
    input  logic     clk,
    input  logic     reset,
    pe_db_if.slave   bus
);
    localparam int A  = ACT_WIDTH;
    localparam int WG = WGT_WIDTH;
    localparam int M  = MULT_OUT_WIDTH;
    localparam int W  = PE_OUT_WIDTH;
    localparam bit SX  = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    typedef enum logic [2:0] {
        OP_WS_FLOW     = 3'b000,
        OP_W_LOAD      = 3'b001,
        OP_NOP_2       = 3'b010,
        OP_W_SWAP_FLOW = 3'b011,
        OP_OS_FLOW     = 3'b100,
        OP_OS_FLUSH    = 3'b101,
        OP_OS_DRAIN    = 3'b110,
        OP_NOP_7       = 3'b111
    } op_e;

    logic [WG-1:0] w_active_q, w_active_d;
    logic [WG-1:0] w_shadow_q, w_shadow_d;
    logic [W-1:0]  acc_q,      acc_d;
    logic [A-1:0]  act_out_q,  act_out_d;
    logic [WG-1:0] wgt_out_q,  wgt_out_d;
    logic [W-1:0]  result_q,   result_d;
    logic          valid_q,    valid_d;
    logic          sat_q,      sat_d;

    op_e           op;
    logic [WG-1:0] wgt_operand;
    logic [W-1:0]  addend;
    logic [M-1:0]  act_ext, wgt_ext, prod;
    logic [W:0]    prod_x, addend_x, sum;
    logic          ovf;
    logic [W-1:0]  clamp_val;
    logic [W-1:0]  mac_val;
    logic          sat_hit;

    // Shared MAC: OS accumulates acc with the streaming weight, WS adds the
    // incoming psum to the stationary weight product.
    always_comb begin
        op          = op_e'(bus.operation_signal_in);
        wgt_operand = (op == OP_OS_FLOW) ? bus.wgt_data_in : w_active_q;
        addend      = (op == OP_OS_FLOW) ? acc_q : bus.result_in;

        act_ext  = {{(M-A){SX & bus.act_data_in[A-1]}}, bus.act_data_in};
        wgt_ext  = {{(M-WG){SX & wgt_operand[WG-1]}}, wgt_operand};
        // Low M bits of the product are identical for signed and unsigned
        // once the operands are extended to M bits.
        prod     = act_ext * wgt_ext;
        prod_x   = {{(W+1-M){SX & prod[M-1]}}, prod};
        addend_x = {SX & addend[W-1], addend};
        sum      = addend_x + prod_x;

        // Signed: the extra bit is the true sign, disagreement with bit W-1
        // means the result left the W-bit range. Unsigned: carry-out.
        if (SX) begin
            ovf       = sum[W] ^ sum[W-1];
            clamp_val = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            ovf       = sum[W];
            clamp_val = {W{1'b1}};
        end

        sat_hit = SAT & ovf;
        mac_val = sat_hit ? clamp_val : sum[W-1:0];
    end

    always_comb begin
        w_active_d = w_active_q;
        w_shadow_d = w_shadow_q;
        acc_d      = acc_q;
        act_out_d  = act_out_q;
        wgt_out_d  = wgt_out_q;
        result_d   = result_q;
        sat_d      = sat_q;
        valid_d    = bus.valid_in;

        if (bus.valid_in) begin
            act_out_d = bus.act_data_in;
            wgt_out_d = bus.wgt_data_in;
            unique case (op)
                OP_WS_FLOW: begin
                    result_d = mac_val;
                    sat_d    = sat_q | sat_hit;
                end
                OP_W_LOAD: begin
                    w_shadow_d = bus.wgt_data_in;
                    result_d   = bus.result_in;
                end
                OP_W_SWAP_FLOW: begin
                    // MAC above already used the old active weight.
                    result_d   = mac_val;
                    sat_d      = sat_q | sat_hit;
                    w_active_d = w_shadow_q;
                end
                OP_OS_FLOW: begin
                    acc_d    = mac_val;
                    result_d = mac_val;
                    sat_d    = sat_q | sat_hit;
                end
                OP_OS_FLUSH: begin
                    result_d = acc_q;
                    acc_d    = '0;
                end
                OP_OS_DRAIN: begin
                    result_d = bus.result_in;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_active_q <= '0;
            w_shadow_q <= '0;
            acc_q      <= '0;
            act_out_q  <= '0;
            wgt_out_q  <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            w_active_q <= w_active_d;
            w_shadow_q <= w_shadow_d;
            acc_q      <= acc_d;
            act_out_q  <= act_out_d;
            wgt_out_q  <= wgt_out_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.act_data_out = act_out_q;
    assign bus.wgt_data_out = wgt_out_q;
    assign bus.result_out   = result_q;
    assign bus.valid_out    = valid_q;
    assign bus.sat_flag     = sat_q;
endmodule

// File: doc/pe_db.md
# pe_db

Parametrised systolic-array processing element, successor to the single-weight PE. It supports two dataflows:
- **Weight-stationary (WS):** MAC against a stationary weight, with partial sums flowing through.
- **Output-stationary (OS):** local accumulation followed by a drain chain.

New over the previous generation: a double-buffered weight (shadow load while computing), signed/unsigned arithmetic, optional saturation with a sticky flag, a valid qualifier, and registered act/wgt forwarding to neighbouring PEs. One instance sits at each array grid point.

## Interface
- ACT_WIDTH, 8, activation width
- WGT_WIDTH, 8, weight width
- MULT_OUT_WIDTH, ACT_WIDTH+WGT_WIDTH, product width
- PE_OUT_WIDTH, 32, psum/accumulator width (must be ≥ MULT_OUT_WIDTH)
- SIGNED, 0, 1 = two's-complement operands and psums; 0 = unsigned
- SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^PE_OUT_WIDTH

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- operation_signal_in  in  3  operation code, encodings listed under Operation
- valid_in  in  1  qualifies the op and data this cycle
- act_data_in  in  ACT_WIDTH  activation from the west neighbour
- wgt_data_in  in  WGT_WIDTH  weight (WS load) or streaming weight (OS) from the north neighbour
- result_in  in  PE_OUT_WIDTH  psum (WS) or drain data (OS) from the upstream PE
- act_data_out  out  ACT_WIDTH  registered act_data_in, to the east neighbour
- wgt_data_out  out  WGT_WIDTH  registered wgt_data_in, to the south neighbour
- result_out  out  PE_OUT_WIDTH  registered result
- valid_out  out  1  registered valid_in
- sat_flag  out  1  sticky overflow indicator

## Operation
Registers: w_active, w_shadow (WGT_WIDTH); acc (PE_OUT_WIDTH); the four output registers; sat_flag.

Datapath rules:
- Product: prod = act × wgt_operand, computed at MULT_OUT_WIDTH.
- Extension: prod is sign-extended to PE_OUT_WIDTH when SIGNED=1, zero-extended otherwise.
- Addition: sum = a + prod, computed at PE_OUT_WIDTH+1 bits for overflow detection.
- SATURATE=1 clamps sum to:
  - signed: [−2^(W−1), 2^(W−1)−1]
  - unsigned: [0, 2^W−1]
- Any clamp sets sat_flag.
- SATURATE=0 truncates sum to W bits; sat_flag stays 0.

Op codes, applied only when valid_in=1:
- **000 WS_FLOW:** result_out ← sat(result_in + act_data_in × w_active).
- **001 W_LOAD:** w_shadow ← wgt_data_in; result_out ← result_in (pass-through).
- **011 W_SWAP_FLOW:** identical to WS_FLOW using the old w_active; in the same edge, w_active ← w_shadow.
- **100 OS_FLOW:** acc ← sat(acc + act_data_in × wgt_data_in); result_out ← the new acc value.
- **101 OS_FLUSH:** result_out ← acc; acc ← 0.
- **110 OS_DRAIN:** result_out ← result_in; acc unchanged.
- **010, 111 NOP:** hold w_active, w_shadow, acc and result_out.

Forwarding and valid:
- act_data_out ← act_data_in and wgt_data_out ← wgt_data_in on every valid cycle, for every op code.
- valid_in=0: no register changes except valid_out.
- valid_out ← valid_in on every cycle.

## Timing
- Latency is 1 cycle for every output: a value applied before edge k appears after edge k.
- No combinational path from input to output.
- Reset (synchronous, active-high): every register is 0 after the edge, including all outputs, sat_flag, w_active, w_shadow and acc. Reset overrides all ops.
- Reset mid-operation: the partial acc and the loaded weights are lost. The host must reload weights.
- W_LOAD during a WS stream is not possible in the same cycle (a single op code per cycle). Shadow loading is interleaved with array-level skew by the controller.
- W_SWAP_FLOW: weights change atomically at the edge. The following cycle's WS_FLOW uses the new weight.
- OS_FLOW immediately after OS_FLUSH accumulates from 0.
- sat_flag clears only on reset.

## Test plan
- **WS with swap:**
  - Stimulus: W_LOAD wgt=3; W_SWAP_FLOW act=0 psum=0; WS_FLOW act=1 psum=0, then act=3 psum=11, then act=6 psum=3.
  - Required response: result_out = 0, 3, 20, 21; act_data_out trails act_data_in by 1 cycle.
- **Double buffer:**
  - Stimulus: active=3; W_LOAD wgt=7; WS_FLOW act=2 psum=1; W_SWAP_FLOW act=2 psum=1; WS_FLOW act=2 psum=1.
  - Required response: 7, 7, 15 (the load does not disturb the active weight).
- **OS flow, flush, drain:**
  - Stimulus: after reset, OS_FLOW (2,2) then (3,3); OS_FLUSH; OS_FLOW (1,5); OS_DRAIN result_in=123.
  - Required response: result_out 4, 13, 13, 5, 123.
- **Signed saturation (SIGNED=1, SATURATE=1, PE_OUT_WIDTH=16):**
  - WS_FLOW psum=32760, act=127, wgt=1 → result_out 32767, sat_flag=1.
  - psum=−32760, act=−128, wgt=1 → −32768.
  - With SATURATE=0, psum=32760, act=127, wgt=1 → 32760+127 wrapped = −32649, sat_flag=0.
- **Valid and NOP hold:**
  - valid_in=0 with op 100 act=9 wgt=9 → acc, result_out and forwarded data unchanged; valid_out=0 the next cycle.
  - Op 111 with valid_in=1 → hold.
- **Reset mid-operation:**
  - Stimulus: acc=13, w_active=3, sat_flag=1; assert reset for 1 cycle.
  - Required response: all outputs 0. A subsequent WS_FLOW act=5 psum=0 gives 0 (weight cleared).
